marker_bbox_tracker: RTL and testbench

//  Scans the camera pixel stream once per frame and finds pixels of the green hand marker.

---
 rtl/marker_bbox_tracker.sv | 85 ++++++++
 tb/tb_marker_bbox_tracker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_bbox_tracker.sv
// marker_bbox_tracker: per-frame extreme points (left/right/up/down) of green marker pixels
// Ports: i_clk/i_rst clock and async reset; i_pix_valid/i_x/i_y/i_rgb pixel stream ([0]=R,[1]=G,[2]=B);
// i_frame_end closes a frame; o_left/o_right/o_up/o_down points ([0]=x,[1]=y); o_found detection flag;
// o_pix_count marker pixels of last frame; o_predict_valid one-cycle update pulse.
module marker_bbox_tracker #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [7:0]  G_MIN      = 8'd120,
  parameter logic [7:0]  DIFF_MIN   = 8'd40,
  parameter int          MIN_PIXELS = 16,
  parameter logic [10:0] NOT_FOUND  = 11'd2023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_valid,
  input  logic [10:0]      i_x,
  input  logic [10:0]      i_y,
  input  logic [2:0][7:0]  i_rgb,
  input  logic             i_frame_end,
  output logic [1:0][10:0] o_left,
  output logic [1:0][10:0] o_right,
  output logic [1:0][10:0] o_up,
  output logic [1:0][10:0] o_down,
  output logic             o_found,
  output logic [15:0]      o_pix_count,
  output logic             o_predict_valid
);
  typedef enum logic [1:0] {S_SYNC, S_ACC, S_LATCH} state_t;
  state_t state;
  logic [15:0] cnt, base, n_cnt;
  logic [1:0][10:0] l, r, u, d, n_l, n_r, n_u, n_d, pt;
  logic latch, mark, hit, first, ok;
  always_comb begin
    latch = state == S_LATCH;
    mark = i_rgb[1] >= G_MIN && {1'b0, i_rgb[1]} >= {1'b0, i_rgb[0]} + {1'b0, DIFF_MIN}
           && {1'b0, i_rgb[1]} >= {1'b0, i_rgb[2]} + {1'b0, DIFF_MIN};
    hit = i_pix_valid && mark && i_x < 11'(H_ACTIVE) && i_y < 11'(V_ACTIVE);
    // a pixel in the latch cycle starts the new frame from cleared accumulators
    base = latch ? '0 : cnt;
    first = base == '0;
    pt = {i_y, i_x};
    n_cnt = hit && base != 16'hFFFF ? base + 16'd1 : base;
    n_l = hit && (first || i_x < l[0]) ? pt : l;
    n_r = hit && (first || i_x > r[0]) ? pt : r;
    n_u = hit && (first || i_y < u[1]) ? pt : u;
    n_d = hit && (first || i_y >= d[1]) ? pt : d;
    ok = cnt >= 16'(MIN_PIXELS);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_SYNC;
      cnt <= '0;
      l <= '0;
      r <= '0;
      u <= '0;
      d <= '0;
      o_left <= {NOT_FOUND, NOT_FOUND};
      o_right <= {NOT_FOUND, NOT_FOUND};
      o_up <= {NOT_FOUND, NOT_FOUND};
      o_down <= {NOT_FOUND, NOT_FOUND};
      o_found <= 1'b0;
      o_pix_count <= '0;
      o_predict_valid <= 1'b0;
    end else begin
      o_predict_valid <= latch;
      if (state != S_SYNC) begin
        cnt <= n_cnt;
        l <= n_l;
        r <= n_r;
        u <= n_u;
        d <= n_d;
      end
      if (latch) begin
        o_left <= ok ? l : {NOT_FOUND, NOT_FOUND};
        o_right <= ok ? r : {NOT_FOUND, NOT_FOUND};
        o_up <= ok ? u : {NOT_FOUND, NOT_FOUND};
        o_down <= ok ? d : {NOT_FOUND, NOT_FOUND};
        o_found <= ok;
        o_pix_count <= cnt;
      end
      state <= state == S_SYNC ? (i_frame_end ? S_ACC : S_SYNC) :
               state == S_ACC ? (i_frame_end ? S_LATCH : S_ACC) : S_ACC;
    end
  end
endmodule

// File: tb/tb_marker_bbox_tracker.sv
// tb_marker_bbox_tracker: directed + random frames against a frame-level reference model, two thresholds
module tb_marker_bbox_tracker;
  logic clk = 1'b0;
  logic rst, pv, fe;
  logic [10:0] x, y;
  logic [2:0][7:0] rgb;
  logic [1:0][10:0] l1, r1, u1, d1, l16, r16, u16, d16;
  logic f1, f16, v1, v16;
  logic [15:0] c1, c16;
  always #5 clk = ~clk;

  marker_bbox_tracker #(.MIN_PIXELS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pv), .i_x(x), .i_y(y), .i_rgb(rgb), .i_frame_end(fe),
    .o_left(l1), .o_right(r1), .o_up(u1), .o_down(d1), .o_found(f1), .o_pix_count(c1),
    .o_predict_valid(v1));
  marker_bbox_tracker #(.MIN_PIXELS(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pv), .i_x(x), .i_y(y), .i_rgb(rgb), .i_frame_end(fe),
    .o_left(l16), .o_right(r16), .o_up(u16), .o_down(d16), .o_found(f16), .o_pix_count(c16),
    .o_predict_valid(v16));

  typedef struct {logic v; logic [10:0] x, y; logic [7:0] r, g, b;} pix_t;
  typedef struct packed {logic [1:0][10:0] l, r, u, d; logic f; logic [15:0] c;} res_t;

  pix_t fr[$];
  pix_t pend[$];
  res_t e1, e16;
  int checks = 0;
  int failures = 0;

  function automatic res_t sentinel();
    res_t o;
    o.l = {11'd2023, 11'd2023};
    o.r = o.l;
    o.u = o.l;
    o.d = o.l;
    o.f = 1'b0;
    o.c = 16'd0;
    return o;
  endfunction

  // frame-level rule: collect marker hits, then pick extremes by the tie rules
  function automatic res_t model(input pix_t q[$], input int minp);
    res_t o;
    pix_t h[$];
    int mnx, mxx, mny, mxy;
    bit got;
    o = sentinel();
    foreach (q[i])
      if (q[i].v && int'(q[i].x) < 640 && int'(q[i].y) < 480 && int'(q[i].g) >= 120 &&
          int'(q[i].g) >= int'(q[i].r) + 40 && int'(q[i].g) >= int'(q[i].b) + 40)
        h.push_back(q[i]);
    o.c = 16'(h.size());
    o.f = h.size() >= minp;
    if (!o.f) return o;
    mnx = 4096; mxx = -1; mny = 4096; mxy = -1;
    foreach (h[i]) begin
      if (int'(h[i].x) < mnx) mnx = int'(h[i].x);
      if (int'(h[i].x) > mxx) mxx = int'(h[i].x);
      if (int'(h[i].y) < mny) mny = int'(h[i].y);
      if (int'(h[i].y) > mxy) mxy = int'(h[i].y);
    end
    got = 0;
    foreach (h[i]) if (!got && int'(h[i].x) == mnx) begin o.l = {h[i].y, h[i].x}; got = 1; end
    got = 0;
    foreach (h[i]) if (!got && int'(h[i].x) == mxx) begin o.r = {h[i].y, h[i].x}; got = 1; end
    got = 0;
    foreach (h[i]) if (!got && int'(h[i].y) == mny) begin o.u = {h[i].y, h[i].x}; got = 1; end
    got = 0;
    for (int i = h.size() - 1; i >= 0; i--)
      if (!got && int'(h[i].y) == mxy) begin o.d = {h[i].y, h[i].x}; got = 1; end
    return o;
  endfunction

  function automatic pix_t mk(input int px, input int py, input int cr, input int cg, input int cb);
    pix_t p;
    p.v = 1'b1;
    p.x = 11'(px);
    p.y = 11'(py);
    p.r = 8'(cr);
    p.g = 8'(cg);
    p.b = 8'(cb);
    return p;
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    int m, g;
    m = int'($urandom_range(0, 4));
    g = (m == 2) ? int'($urandom_range(118, 122)) : int'($urandom_range(120, 255));
    p.v = $urandom_range(0, 9) != 0;
    p.x = (m == 4) ? 11'($urandom_range(600, 700)) : (m == 3) ? 11'($urandom_range(10, 13)) : 11'($urandom_range(0, 639));
    p.y = (m == 4) ? 11'($urandom_range(440, 520)) : (m == 3) ? 11'($urandom_range(20, 22)) : 11'($urandom_range(0, 479));
    p.g = (m == 0) ? 8'($urandom) : 8'(g);
    p.r = (m == 0) ? 8'($urandom) : (m == 2) ? 8'(g - 41 + int'($urandom_range(0, 2))) : 8'($urandom_range(0, g - 40));
    p.b = (m == 0) ? 8'($urandom) : 8'($urandom_range(0, g - 40));
    return p;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input pix_t p, input logic e);
    pv = p.v;
    x = p.x;
    y = p.y;
    rgb = {p.b, p.g, p.r};
    fe = e;
  endtask

  task automatic idle(input logic e);
    pv = 1'b0;
    x = 11'($urandom_range(0, 639));
    y = 11'($urandom_range(0, 479));
    rgb = {8'd0, 8'd255, 8'd0};
    fe = e;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, " left1"}, 32'(l1), 32'(e1.l));
    chk({tag, " right1"}, 32'(r1), 32'(e1.r));
    chk({tag, " up1"}, 32'(u1), 32'(e1.u));
    chk({tag, " down1"}, 32'(d1), 32'(e1.d));
    chk({tag, " found1"}, 32'(f1), 32'(e1.f));
    chk({tag, " count1"}, 32'(c1), 32'(e1.c));
    chk({tag, " left16"}, 32'(l16), 32'(e16.l));
    chk({tag, " right16"}, 32'(r16), 32'(e16.r));
    chk({tag, " up16"}, 32'(u16), 32'(e16.u));
    chk({tag, " down16"}, 32'(d16), 32'(e16.d));
    chk({tag, " found16"}, 32'(f16), 32'(e16.f));
    chk({tag, " count16"}, 32'(c16), 32'(e16.c));
  endtask

  // sends fr, closes the frame; optional pixel (and ignored frame_end) in the latch cycle
  task automatic run_frame(input string tag, input bit expect_pulse, input bit overlap,
                           input bit latch_pix, input bit latch_fe);
    pix_t all[$];
    pix_t lp;
    foreach (pend[i]) all.push_back(pend[i]);
    foreach (fr[i]) all.push_back(fr[i]);
    pend.delete();
    foreach (fr[i]) begin
      drive(fr[i], overlap && i == fr.size() - 1);
      tick();
    end
    if (!overlap || fr.size() == 0) begin
      idle(1'b1);
      tick();
    end
    chk({tag, " pulse_early1"}, 32'(v1), 0);
    chk({tag, " pulse_early16"}, 32'(v16), 0);
    if (latch_pix) begin
      lp = rand_pix();
      drive(lp, latch_fe);
      pend.push_back(lp);
    end else idle(latch_fe);
    tick();
    if (expect_pulse) begin
      e1 = model(all, 1);
      e16 = model(all, 16);
    end
    chk({tag, " pulse1"}, 32'(v1), 32'(expect_pulse));
    chk({tag, " pulse16"}, 32'(v16), 32'(expect_pulse));
    check_out(tag);
    idle(1'b0);
    tick();
    chk({tag, " pulse_after1"}, 32'(v1), 0);
    chk({tag, " pulse_after16"}, 32'(v16), 0);
    check_out({tag, " hold"});
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    e1 = sentinel();
    e16 = sentinel();
    tick();
    tick();
    chk("reset pulse", 32'(v1), 0);
    check_out("reset");
    rst = 1'b0;
    // frame discarded after reset, then one-pixel frame
    fr.delete();
    fr.push_back(mk(5, 5, 10, 200, 10));
    run_frame("sync", 0, 0, 0, 0);
    fr.delete();
    fr.push_back(mk(100, 200, 10, 200, 10));
    run_frame("single", 1, 0, 0, 0);
    fr.delete();
    fr.push_back(mk(10, 10, 200, 200, 200));
    fr.push_back(mk(11, 10, 0, 100, 0));
    run_frame("empty", 1, 0, 0, 0);
    fr.delete();
    for (int j = 50; j <= 54; j++)
      for (int i = 300; i <= 304; i++) fr.push_back(mk(i, j, 20, 220, 30));
    run_frame("block", 1, 0, 0, 0);
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(mk(400 + i, 100, 0, 180, 0));
    run_frame("ten", 1, 0, 0, 0);
    fr.delete();
    fr.push_back(mk(700, 10, 0, 200, 0));
    fr.push_back(mk(10, 500, 0, 200, 0));
    fr.push_back(mk(20, 20, 170, 200, 10));
    run_frame("reject", 1, 0, 0, 0);
    fr.delete();
    fr.push_back(mk(639, 479, 0, 200, 0));
    fr.push_back(mk(0, 0, 80, 120, 80));
    fr.push_back(mk(1, 1, 0, 119, 0));
    fr.push_back(mk(640, 2, 0, 200, 0));
    fr.push_back(mk(3, 480, 0, 200, 0));
    run_frame("edges", 1, 1, 1, 1);
    for (int k = 0; k < 40; k++) begin
      fr.delete();
      repeat ($urandom_range(0, 40)) fr.push_back(rand_pix());
      run_frame($sformatf("rand%0d", k), 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    fr.delete();
    for (int i = 0; i < 20; i++) fr.push_back(mk(200 + i, 300 - i, 0, 250, 0));
    run_frame("prereset", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(mk(50 + i, 60, 0, 250, 0), 1'b0);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    e1 = sentinel();
    e16 = sentinel();
    pend.delete();
    chk("midreset pulse", 32'(v1), 0);
    check_out("midreset");
    idle(1'b0);
    tick();
    tick();
    rst = 1'b0;
    fr.delete();
    for (int i = 0; i < 20; i++) fr.push_back(mk(90 + i, 90, 0, 250, 0));
    run_frame("postreset_sync", 0, 0, 0, 0);
    fr.delete();
    for (int i = 0; i < 18; i++) fr.push_back(mk(30, 40 + i, 0, 250, 0));
    run_frame("postreset", 1, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
